// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : control_sequencer
// Purpose : Multi-cycle control unit. Fetches a 16-bit instruction, decodes
//           it and drives the datapath register selects, ALU function select,
//           mux selects and memory/register write strobes.
//           State flow: FETCH -> DECODE -> EXEC -> (MEM) -> FETCH, or HALT.
// Ports   : clk_main, reset          clock, synchronous active-high reset
//           instr_in, instr_valid    instruction word and its qualifier
//           mem_ready                data-memory completion strobe (LD/ST)
//           V, C, N, Z               datapath status flags (Z used by BRZ)
//           fetch_req, pc            instruction request, program counter
//           DR, SA, SB, AX, BX, DX   register selects (AX/BX/DX reserved, 0)
//           FS, MB, MM, MD, MW, RW   function select, muxes, write strobes
//           halted, illegal          status flags
// Revision: 1.0 - initial release
// ============================================================================
module control_sequencer #(
  parameter int NBIT = 16,
  parameter int PCW  = 8
) (
  input  logic            clk_main,
  input  logic            reset,
  input  logic [NBIT-1:0] instr_in,
  input  logic            instr_valid,
  input  logic            mem_ready,
  input  logic            V,
  input  logic            C,
  input  logic            N,
  input  logic            Z,
  output logic            fetch_req,
  output logic [PCW-1:0]  pc,
  output logic [2:0]      DR,
  output logic [2:0]      SA,
  output logic [2:0]      SB,
  output logic [3:0]      AX,
  output logic [3:0]      BX,
  output logic [3:0]      DX,
  output logic [3:0]      FS,
  output logic            MB,
  output logic            MM,
  output logic            MD,
  output logic            MW,
  output logic            RW,
  output logic            halted,
  output logic            illegal
);

  localparam logic [3:0] c_OP_NOP  = 4'h0;
  localparam logic [3:0] c_OP_ADD  = 4'h1;
  localparam logic [3:0] c_OP_SUB  = 4'h2;
  localparam logic [3:0] c_OP_AND  = 4'h3;
  localparam logic [3:0] c_OP_OR   = 4'h4;
  localparam logic [3:0] c_OP_LD   = 4'h6;
  localparam logic [3:0] c_OP_ST   = 4'h7;
  localparam logic [3:0] c_OP_BRZ  = 4'h8;
  localparam logic [3:0] c_OP_JMP  = 4'h9;
  localparam logic [3:0] c_OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [NBIT-1:0] ir_q, ir_d;
  logic            illegal_q, illegal_d;

  // Instruction fields (off overlaps sb by design of the encoding)
  logic [3:0]     w_op;
  logic [2:0]     w_dr, w_sa, w_sb;
  logic [PCW-1:0] w_off_sext;
  logic [PCW-1:0] w_pc_inc;
  logic           w_legal;

  assign w_op       = ir_q[15:12];
  assign w_dr       = ir_q[11:9];
  assign w_sa       = ir_q[8:6];
  assign w_sb       = ir_q[5:3];
  assign w_off_sext = {{(PCW-6){ir_q[5]}}, ir_q[5:0]};
  assign w_pc_inc   = pc_q + PCW'(1);

  always_comb begin
    unique case (w_op)
      c_OP_NOP, c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR,
      c_OP_LD, c_OP_ST, c_OP_BRZ, c_OP_JMP, c_OP_HALT: w_legal = 1'b1;
      default:                                          w_legal = 1'b0;
    endcase
  end

  // Flags V/C/N are part of the datapath interface but no instruction uses them
  logic unused_flags;
  assign unused_flags = ^{V, C, N};

  assign pc      = pc_q;
  assign illegal = illegal_q;
  assign AX      = 4'b0000;
  assign BX      = 4'b0000;
  assign DX      = 4'b0000;

  always_ff @(posedge clk_main) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    fetch_req = 1'b0;
    halted    = 1'b0;
    DR        = 3'd0;
    SA        = 3'd0;
    SB        = 3'd0;
    FS        = 4'b0000;
    MB        = 1'b0;
    MM        = 1'b0;
    MD        = 1'b0;
    MW        = 1'b0;
    RW        = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (instr_valid) begin
          ir_d    = instr_in;
          state_d = S_DECODE;
        end
      end

      // Illegal is flagged on leaving DECODE so it is visible from EXEC on
      S_DECODE: begin
        state_d = S_EXEC;
        if (!w_legal) illegal_d = 1'b1;
      end

      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = w_pc_inc;
        unique case (w_op)
          c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR: begin
            DR = w_dr;
            SA = w_sa;
            SB = w_sb;
            RW = 1'b1;
            unique case (w_op)
              c_OP_ADD: FS = 4'b0010;
              c_OP_SUB: FS = 4'b0101;
              c_OP_AND: FS = 4'b1000;
              default:  FS = 4'b1001;
            endcase
          end
          c_OP_BRZ: begin
            SA = w_sa;
            if (Z) pc_d = pc_q + w_off_sext;
          end
          c_OP_JMP: pc_d = pc_q + w_off_sext;
          c_OP_LD, c_OP_ST: begin
            state_d = S_MEM;
            pc_d    = pc_q;
          end
          c_OP_HALT: begin
            state_d = S_HALT;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end

      // Address/data selects are held for the whole access; the register
      // write for LD only fires in the completion cycle.
      S_MEM: begin
        SA = w_sa;
        if (w_op == c_OP_LD) begin
          DR = w_dr;
          MD = 1'b1;
          RW = mem_ready;
        end else begin
          SB = w_sb;
          MW = 1'b1;
        end
        if (mem_ready) begin
          pc_d    = w_pc_inc;
          state_d = S_FETCH;
        end
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_FETCH;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_control_sequencer
// Purpose : Self-checking bench for control_sequencer. Each instruction is
//           expanded into its expected per-cycle output trace from the
//           instruction semantics; a compare process checks every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

  logic        clk_main = 1'b0;
  logic        reset = 1'b1, instr_valid = 1'b0, mem_ready = 1'b0;
  logic        V = 1'b0, C = 1'b0, N = 1'b0, Z = 1'b0;
  logic [15:0] instr_in = '0;
  logic        fetch_req, MB, MM, MD, MW, RW, halted, illegal;
  logic [7:0]  pc;
  logic [2:0]  DR, SA, SB;
  logic [3:0]  AX, BX, DX, FS;

  always #5 clk_main = ~clk_main;

  control_sequencer #(.NBIT(16), .PCW(8)) dut (
    .clk_main(clk_main), .reset(reset), .instr_in(instr_in),
    .instr_valid(instr_valid), .mem_ready(mem_ready),
    .V(V), .C(C), .N(N), .Z(Z),
    .fetch_req(fetch_req), .pc(pc), .DR(DR), .SA(SA), .SB(SB),
    .AX(AX), .BX(BX), .DX(DX), .FS(FS),
    .MB(MB), .MM(MM), .MD(MD), .MW(MW), .RW(RW),
    .halted(halted), .illegal(illegal)
  );

  typedef struct packed {
    logic       fetch_req;
    logic [7:0] pc;
    logic [2:0] dr, sa, sb;
    logic [3:0] fs;
    logic       mb, mm, md, mw, rw, halted, illegal;
    logic       pin_pc_en;
    logic [7:0] pin_pc;
    logic       pin_ill_en, pin_ill, pin_f_en, pin_f;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  int         total = 0;
  int         bad = 0;
  logic [7:0] m_pc = '0;
  logic       m_ill = 1'b0;
  logic [3:0] fs_tab [16];
  logic       pend_pc_en = 1'b0, pend_ill_en = 1'b0, pend_f_en = 1'b0;
  logic [7:0] pend_pc = '0;
  logic       pend_ill = 1'b0, pend_f = 1'b0;

  // ---------------- compare process ----------------
  always @(negedge clk_main) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      total++;
      if ({fetch_req, pc, DR, SA, SB, FS, MB, MM, MD, MW, RW, halted, illegal, AX, BX, DX} !==
          {cur.fetch_req, cur.pc, cur.dr, cur.sa, cur.sb, cur.fs, cur.mb, cur.mm,
           cur.md, cur.mw, cur.rw, cur.halted, cur.illegal, 12'h000}) begin
        bad++;
        $display("FAIL cycle_check t=%0t got fr=%b pc=%0d DR=%0d SA=%0d SB=%0d FS=%b MB=%b MM=%b MD=%b MW=%b RW=%b H=%b I=%b AX=%h BX=%h DX=%h | want fr=%b pc=%0d DR=%0d SA=%0d SB=%0d FS=%b MB=%b MM=%b MD=%b MW=%b RW=%b H=%b I=%b",
                 $time, fetch_req, pc, DR, SA, SB, FS, MB, MM, MD, MW, RW, halted, illegal, AX, BX, DX,
                 cur.fetch_req, cur.pc, cur.dr, cur.sa, cur.sb, cur.fs, cur.mb, cur.mm,
                 cur.md, cur.mw, cur.rw, cur.halted, cur.illegal);
      end
      if (cur.pin_pc_en) begin
        total++;
        if (pc !== cur.pin_pc) begin
          bad++;
          $display("FAIL pin_pc t=%0t got %0d want %0d", $time, pc, cur.pin_pc);
        end
      end
      if (cur.pin_ill_en) begin
        total++;
        if (illegal !== cur.pin_ill) begin
          bad++;
          $display("FAIL pin_illegal t=%0t got %b want %b", $time, illegal, cur.pin_ill);
        end
      end
      if (cur.pin_f_en) begin
        total++;
        if (fetch_req !== cur.pin_f) begin
          bad++;
          $display("FAIL pin_fetch_req t=%0t got %b want %b", $time, fetch_req, cur.pin_f);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic rb();
    return 1'($urandom & 1);
  endfunction

  function automatic exp_t idle_e(input logic f);
    exp_t e;
    e           = '0;
    e.fetch_req = f;
    e.pc        = m_pc;
    e.illegal   = m_ill;
    return e;
  endfunction

  // Hand-computed literal expectations for the next checked cycle
  task automatic pin(input logic pc_en, input logic [7:0] pv,
                     input logic ill_en, input logic iv,
                     input logic f_en, input logic fv);
    pend_pc_en = pc_en; pend_pc = pv;
    pend_ill_en = ill_en; pend_ill = iv;
    pend_f_en = f_en; pend_f = fv;
  endtask

  task automatic step(input logic rst, input logic iv, input logic mr,
                      input logic z, input logic [15:0] ins,
                      input exp_t e, input bit chk);
    exp_t r;
    reset       = rst;
    instr_valid = iv;
    instr_in    = ins;
    mem_ready   = mr;
    Z           = z;
    {V, C, N}   = 3'($urandom);
    if (chk) begin
      r            = e;
      r.pin_pc_en  = pend_pc_en;  r.pin_pc  = pend_pc;
      r.pin_ill_en = pend_ill_en; r.pin_ill = pend_ill;
      r.pin_f_en   = pend_f_en;   r.pin_f   = pend_f;
      exp_q.push_back(r);
      pend_pc_en = 1'b0; pend_ill_en = 1'b0; pend_f_en = 1'b0;
    end
    @(posedge clk_main);
    #1;
  endtask

  // Reset cycle: outputs still reflect the pre-reset state (e)
  task automatic do_reset(input exp_t e);
    step(1'b1, rb(), rb(), rb(), 16'($urandom), e, 1'b1);
    m_pc  = '0;
    m_ill = 1'b0;
  endtask

  // Expand one instruction into its expected cycle trace.
  // zsel < 0: random Z; rst_mem >= 0: reset in that MEM cycle (with mem_ready=1)
  task automatic run_instr(input logic [15:0] ins, input int gap, input int mdly,
                           input int zsel, input int rst_mem, input int hcyc);
    logic [3:0] op;
    int         soff;
    int         nxt;
    exp_t       e;
    logic       z;
    op   = ins[15:12];
    soff = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
    for (int i = 0; i < gap; i++)
      step(1'b0, 1'b0, rb(), rb(), 16'($urandom), idle_e(1'b1), 1'b1);
    step(1'b0, 1'b1, rb(), rb(), ins, idle_e(1'b1), 1'b1);
    step(1'b0, rb(), rb(), rb(), 16'($urandom), idle_e(1'b0), 1'b1);
    if (!(op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'hF}))
      m_ill = 1'b1;
    z   = (zsel < 0) ? rb() : zsel[0];
    e   = idle_e(1'b0);
    nxt = (int'(m_pc) + 1) % 256;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4: begin
        e.dr = ins[11:9]; e.sa = ins[8:6]; e.sb = ins[5:3];
        e.fs = fs_tab[op]; e.rw = 1'b1;
      end
      4'h8: begin
        e.sa = ins[8:6];
        if (z) nxt = (int'(m_pc) + soff + 256) % 256;
      end
      4'h9: nxt = (int'(m_pc) + soff + 256) % 256;
      default: ;
    endcase
    step(1'b0, rb(), rb(), z, 16'($urandom), e, 1'b1);
    if (op == 4'h6 || op == 4'h7) begin
      for (int i = 0; i <= mdly; i++) begin
        e    = idle_e(1'b0);
        e.sa = ins[8:6];
        if (op == 4'h6) begin
          e.dr = ins[11:9]; e.md = 1'b1; e.rw = (i == mdly);
        end else begin
          e.sb = ins[5:3]; e.mw = 1'b1;
        end
        if (i == rst_mem) begin
          e.rw = (op == 4'h6);
          step(1'b1, rb(), 1'b1, rb(), 16'($urandom), e, 1'b1);
          m_pc  = '0;
          m_ill = 1'b0;
          return;
        end
        step(1'b0, rb(), (i == mdly), rb(), 16'($urandom), e, 1'b1);
      end
    end
    if (op == 4'hF) begin
      for (int i = 0; i < hcyc; i++) begin
        e = idle_e(1'b0);
        e.halted = 1'b1;
        step(1'b0, rb(), rb(), rb(), 16'($urandom), e, 1'b1);
      end
      return;
    end
    m_pc = 8'(nxt);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    exp_t e;
    logic [15:0] ins;
    for (int i = 0; i < 16; i++) fs_tab[i] = 4'b0000;
    fs_tab[1] = 4'b0010; fs_tab[2] = 4'b0101;
    fs_tab[3] = 4'b1000; fs_tab[4] = 4'b1001;

    // Reset: first cycle unknown state, second cycle checked
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, idle_e(1'b1), 1'b0);
    do_reset(idle_e(1'b1));
    pin(1'b1, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);

    // ADD r1 <- r2 + r3 at pc 0
    run_instr(16'h1298, 0, 0, -1, -1, 0);
    pin(1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    // LD with mem_ready 5 cycles late
    run_instr(16'h64C0, 1, 5, -1, -1, 0);
    pin(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    // BRZ -4 at pc 2, Z=1 -> 254
    run_instr(16'h803C, 0, 0, 1, -1, 0);
    pin(1'b1, 8'd254, 1'b0, 1'b0, 1'b0, 1'b0);
    // Back to pc 2, BRZ -4 with Z=0 -> 3
    do_reset(idle_e(1'b1));
    run_instr(16'h0000, 0, 0, -1, -1, 0);
    run_instr(16'h0000, 2, 0, -1, -1, 0);
    run_instr(16'h803C, 0, 0, 0, -1, 0);
    pin(1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    // Illegal opcode B, then a normal SUB with illegal still set
    run_instr(16'hB123, 0, 0, -1, -1, 0);
    pin(1'b1, 8'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    run_instr(16'h2A50, 0, 0, -1, -1, 0);
    pin(1'b1, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    // Wrap: JMP -1 from 0 -> 255, then NOP -> 0
    do_reset(idle_e(1'b1));
    run_instr(16'h903F, 0, 0, -1, -1, 0);
    pin(1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(16'h0000, 0, 0, -1, -1, 0);
    pin(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Reset during ST in MEM: no completion, pc back to 0
    run_instr(16'h0000, 0, 0, -1, -1, 0);
    run_instr(16'h7ED8, 0, 4, -1, 2, 0);
    pin(1'b1, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      ins = {4'($urandom_range(14, 0)), 12'($urandom)};
      run_instr(ins, int'($urandom_range(3, 0)), int'($urandom_range(4, 0)), -1, -1, 0);
      if ($urandom_range(39, 0) == 0) do_reset(idle_e(1'b1));
    end

    // HALT for 20 cycles, then reset releases it
    run_instr(16'hF000, 0, 0, -1, -1, 20);
    e = idle_e(1'b0);
    e.halted = 1'b1;
    do_reset(e);
    pin(1'b1, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    run_instr(16'h0000, 0, 0, -1, -1, 0);

    @(negedge clk_main);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter NBIT, default 16, the instruction word width (fixed at 16 for this block).
REQ-002 SHALL have parameter PCW, default 8, the program counter width.
REQ-003 SHALL have port clk_main, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port instr_in, input, 16, the instruction word presented by program memory.
REQ-006 SHALL have port instr_valid, input, 1, meaning instr_in is valid this cycle.
REQ-007 SHALL have port mem_ready, input, 1, the data-memory completion strobe for LD/ST.
REQ-008 SHALL have ports V, C, N, Z, input, 1 each, the datapath status flags.
REQ-009 SHALL have port fetch_req, output, 1, the instruction request, high only in FETCH.
REQ-010 SHALL have port pc, output, PCW, the current program counter.
REQ-011 SHALL have ports DR, SA, SB, output, 3 each, the register selects.
REQ-012 SHALL have ports AX, BX, DX, output, 4 each, reserved selects, constant 4'b0000.
REQ-013 SHALL have port FS, output, 4, the function select.
REQ-014 SHALL have ports MB, MM, MD, MW, RW, output, 1 each, the mux selects, memory write and register write.
REQ-015 SHALL have ports halted and illegal, output, 1 each, the status flags.

Function
REQ-016 SHALL decode instr_in as opcode[15:12], dr[11:9], sa[8:6], sb[5:3], off[5:0] (two's complement).
REQ-017 SHALL support these opcodes, with FS given per opcode:
- 0 NOP
- 1 ADD, FS=0010
- 2 SUB, FS=0101
- 3 AND, FS=1000
- 4 OR, FS=1001
- 6 LD
- 7 ST
- 8 BRZ
- 9 JMP
- F HALT
REQ-018 SHALL treat every other opcode as NOP and set illegal, which stays set until reset.
REQ-019 SHALL implement the states FETCH, DECODE, EXEC, MEM and HALT.
REQ-020 SHALL, in FETCH, hold fetch_req=1; on instr_valid it latches IR and moves to DECODE, otherwise it stays in FETCH.
REQ-021 SHALL, in DECODE, spend one cycle with all controls idle, then move to EXEC.
REQ-022 SHALL, for ALU ops in EXEC, drive for one cycle: DR=dr, SA=sa, SB=sb, FS per opcode, MB=0, MD=0, RW=1, then pc+1 and FETCH.
REQ-023 SHALL, for BRZ in EXEC, drive SA=sa and FS=0000 (transfer A) and sample Z; if Z=1, pc<=pc+sext(off), else pc<=pc+1; RW=0; then FETCH.
REQ-024 SHALL, for JMP in EXEC, set pc<=pc+sext(off) unconditionally, then FETCH.
REQ-025 SHALL, for LD/ST, go EXEC->MEM and hold SA=sa and MM=0 throughout MEM; LD holds DR=dr, MD=1; ST holds SB=sb, MW=1.
REQ-026 SHALL, in MEM, raise RW=1 (LD only) in the cycle mem_ready=1, then pc+1 and FETCH; without mem_ready it waits indefinitely.
REQ-027 SHALL, for HALT, enter HALT with halted=1 and all controls idle, remaining there until reset.
REQ-028 SHALL define idle controls as: DR=SA=SB=0, FS=0000, MB=MM=MD=MW=RW=0.
REQ-029 SHALL compute pc arithmetic modulo 2^PCW, so 255+1=0 and 2+sext(-4)=254.
REQ-030 SHALL ignore instr_valid outside FETCH and mem_ready outside MEM.
REQ-031 SHALL give minimum latencies of 3 cycles for ALU/BRZ/JMP and 4 cycles for LD/ST, from fetch_req to the next fetch_req.
REQ-032 SHALL never assert MW and RW in the same cycle.

Reset
REQ-033 SHALL, on reset=1 at a clock edge, set: state=FETCH, pc=0, IR=0, controls idle, halted=0, illegal=0.
REQ-034 SHALL give reset priority over every other event, including mid-MEM and in HALT; a pending MW deasserts the next cycle and no write completes.

Verification
REQ-035 SHALL be checked with: ADD 0x1298 (dr=1, sa=2, sb=3) with instr_valid in cycle 1 -> EXEC in cycle 3 shows DR=1, SA=2, SB=3, FS=0010, RW=1; pc=1 afterwards.
REQ-036 SHALL be checked with: LD with mem_ready delayed 5 cycles -> MD=1 held 5 cycles, RW=1 only in the mem_ready cycle, MW=0 throughout.
REQ-037 SHALL be checked with: BRZ off=-4 at pc=2, Z=1 -> pc=254; the same with Z=0 -> pc=3.
REQ-038 SHALL be checked with: opcode B -> illegal=1 and no RW/MW; the next instruction executes normally with illegal still 1.
REQ-039 SHALL be checked with: HALT -> halted=1 and fetch_req=0 for 20 cycles; reset -> pc=0, fetch_req=1 the next cycle.
REQ-040 SHALL be checked with: reset asserted during ST in MEM -> MW=0 the following cycle, state FETCH, pc=0.
